kbd_ctrl: RTL and testbench
===========================

KBD_CTRL -- requirements
Module: kbd_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning FIFO entries (power of two, 2..16).
REQ-002 SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port keyboard_data, input, 8, received scancode byte from the PS/2 receiver.
REQ-005 SHALL have port keyboard_rdy, input, 1, one-cycle strobe that keyboard_data is valid.
REQ-006 SHALL have port en, input, 1, bus access select.
REQ-007 SHALL have port wr, input, 1, bus write (1) / read (0).
REQ-008 SHALL have port addr, input, 1, register select: 0 = status/control, 1 = data.
REQ-009 SHALL have port data_in, input, 32, bus write data.
REQ-010 SHALL have port data_out, output, 32, bus read data.
REQ-011 SHALL have port wt, output, 1, bus wait; constant 0, so every access completes in one cycle.
REQ-012 SHALL have port irq, output, 1, interrupt request.

Function
REQ-013 The prefix decoder SHALL be an FSM with states IDLE, EXT, BRK and EXTBRK, acting only on cycles with keyboard_rdy=1.
REQ-014 Transitions SHALL be: IDLE+E0->EXT; IDLE+F0->BRK; EXT+F0->EXTBRK; any state+E0 other than IDLE->EXT; BRK/EXTBRK+F0->BRK/EXTBRK (no change).
REQ-015 Any other byte except 00/FF SHALL emit the event {ext,brk,code[7:0]}, with ext=1 in EXT/EXTBRK and brk=1 in BRK/EXTBRK, and the FSM SHALL return to IDLE.
REQ-016 Bytes 00 and FF SHALL emit no event, set sticky flag err and return the FSM to IDLE.
REQ-017 An emitted event SHALL be pushed into a DEPTH-entry 10-bit FIFO in the cycle after the keyboard_rdy strobe and be visible to a read in that cycle.
REQ-018 A push while the FIFO is full SHALL drop the new event, keep the existing contents and set sticky flag ovf.
REQ-019 A status read (en=1, wr=0, addr=0) SHALL return: bit0 = not empty, bit1 = ie, bit2 = ovf, bit3 = err, bits[8:4] = entry count, all other bits 0.
REQ-020 A status write SHALL load ie from data_in[1]; data_in[2]=1 SHALL clear ovf and data_in[3]=1 SHALL clear err (write-1-to-clear).
REQ-021 A data read (en=1, wr=0, addr=1) SHALL return {22'b0, ext, brk, code} of the head entry and pop it in the same cycle; on an empty FIFO it SHALL return 0 and not pop.
REQ-022 Data writes SHALL be ignored.
REQ-023 data_out SHALL be combinational from the current state and SHALL be 0 when en=0.
REQ-024 A simultaneous push and pop SHALL both take effect; the count stays unchanged and FIFO order is preserved, including when the FIFO is full.
REQ-025 A simultaneous flag set (REQ-016/018) and write-1-to-clear SHALL leave the flag set.
REQ-026 irq SHALL be registered and equal ie AND not-empty, updating one cycle after the state change.
REQ-027 FIFO pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH.

Reset
REQ-028 While rst_n=0: FSM = IDLE, FIFO empty (count 0, pointers 0), ie=0, ovf=0, err=0, irq=0, data_out=0, wt=0.
REQ-029 A reset asserted mid-sequence (for example after E0 or F0) SHALL discard the partial prefix and all queued events.

Verification
REQ-030 Bytes 1C, then F0 1C -> data reads return 0x01C then 0x11C; status bit0 = 0 afterwards.
REQ-031 Bytes E0 F0 75 -> single event 0x375; E0 F0 E0 75 -> 0x275.
REQ-032 ie=1, push one byte 29 -> irq rises one cycle after the push; data read -> irq falls one cycle later.
REQ-033 DEPTH+1 bytes with no reads -> count = DEPTH, ovf = 1, head = first byte; write 0x4 to status -> ovf = 0.
REQ-034 Byte FF -> no event, err = 1; a push coincident with a pop while full -> count stays DEPTH, order intact.
REQ-035 rst_n pulse after E0 -> subsequent byte 6B yields 0x06B; count = 0 immediately after the reset.

Source files
------------

// File: rtl/kbd_ctrl.sv
// PS/2 scancode front end: decodes E0/F0 prefixes into 10-bit key events,
// queues them in a FIFO and exposes a status/data register pair on a simple bus.
module kbd_ctrl #(
  parameter int unsigned DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  keyboard_data,
  input  logic        keyboard_rdy,
  input  logic        en,
  input  logic        wr,
  input  logic        addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        wt,
  output logic        irq
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXTBRK} state_t;

  state_t          state_q, state_d;
  logic            ev_valid;
  logic            bad_byte;
  logic [9:0]      ev_data;

  logic [9:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ie_q, ie_d;
  logic            ovf_q, ovf_d;
  logic            err_q, err_d;
  logic            irq_q, irq_d;

  logic            empty, full;
  logic            rd_status, rd_data, wr_status;
  logic            push, pop, ovf_set;
  logic            unused_data_in;

  assign unused_data_in = ^{data_in[31:4], data_in[0]};

  always_comb begin
    state_d  = state_q;
    ev_valid = 1'b0;
    bad_byte = 1'b0;
    ev_data  = {(state_q == EXT) || (state_q == EXTBRK),
                (state_q == BRK) || (state_q == EXTBRK),
                keyboard_data};
    if (keyboard_rdy) begin
      if (keyboard_data == 8'hE0) begin
        state_d = EXT;
      end else if (keyboard_data == 8'hF0) begin
        case (state_q)
          IDLE:    state_d = BRK;
          EXT:     state_d = EXTBRK;
          default: state_d = state_q;
        endcase
      end else if ((keyboard_data == 8'h00) || (keyboard_data == 8'hFF)) begin
        bad_byte = 1'b1;
        state_d  = IDLE;
      end else begin
        ev_valid = 1'b1;
        state_d  = IDLE;
      end
    end
  end

  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign rd_status = en & ~wr & ~addr;
  assign rd_data   = en & ~wr & addr;
  assign wr_status = en & wr & ~addr;

  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign pop     = rd_data & ~empty;
  assign push    = ev_valid & (~full | pop);
  assign ovf_set = ev_valid & full & ~pop;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
    ie_d  = wr_status ? data_in[1] : ie_q;
    ovf_d = (ovf_q & ~(wr_status & data_in[2])) | ovf_set;
    err_d = (err_q & ~(wr_status & data_in[3])) | bad_byte;
    irq_d = ie_q & ~empty;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ie_q     <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ie_q     <= ie_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
      irq_q    <= irq_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= ev_data;
  end

  always_comb begin
    data_out = '0;
    if (rd_status) begin
      data_out[0]   = ~empty;
      data_out[1]   = ie_q;
      data_out[2]   = ovf_q;
      data_out[3]   = err_q;
      data_out[8:4] = 5'(count_q);
    end else if (rd_data && !empty) begin
      data_out[9:0] = mem_q[rd_ptr_q];
    end
  end

  assign wt  = 1'b0;
  assign irq = irq_q;

endmodule

// File: tb/tb_kbd_ctrl.sv
// Randomised and directed checks of kbd_ctrl against a queue-based event model.
module tb_kbd_ctrl;

  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  kb_data = '0;
  logic        kb_rdy = 1'b0;
  logic        en = 1'b0, wr = 1'b0, addr = 1'b0;
  logic [31:0] din = '0;
  logic [31:0] data_out;
  logic        wt, irq;

  kbd_ctrl #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .keyboard_data(kb_data), .keyboard_rdy(kb_rdy),
    .en(en), .wr(wr), .addr(addr), .data_in(din),
    .data_out(data_out), .wt(wt), .irq(irq)
  );

  always #5 clk = ~clk;

  // Model state: pending prefix flags, event queue, sticky flags, lagged irq.
  logic [9:0]  q[$];
  bit          m_ext, m_brk, m_ie, m_ovf, m_err, m_irq;
  int unsigned n_checks = 0, n_fail = 0;
  bit          chk_en = 1'b0;
  logic [31:0] last_dout;
  logic        last_irq;

  function automatic logic [31:0] model_dout();
    logic [31:0] r;
    r = '0;
    if (rst_n && en && !wr) begin
      if (!addr) begin
        r[0]   = (q.size() != 0);
        r[1]   = m_ie;
        r[2]   = m_ovf;
        r[3]   = m_err;
        r[8:4] = 5'(q.size());
      end else if (q.size() != 0) begin
        r[9:0] = q[0];
      end
    end
    return r;
  endfunction

  task automatic model_clear();
    q.delete();
    m_ext = 0; m_brk = 0; m_ie = 0; m_ovf = 0; m_err = 0; m_irq = 0;
  endtask

  task automatic model_step();
    bit irq_next, ovf_set, err_set;
    irq_next = m_ie && (q.size() != 0);
    ovf_set  = 0;
    err_set  = 0;
    if (en && !wr && addr && q.size() != 0) void'(q.pop_front());
    if (kb_rdy) begin
      if (kb_data == 8'hE0) begin
        m_ext = 1; m_brk = 0;
      end else if (kb_data == 8'hF0) begin
        m_brk = 1;
      end else if (kb_data == 8'h00 || kb_data == 8'hFF) begin
        err_set = 1; m_ext = 0; m_brk = 0;
      end else begin
        if (q.size() < DEPTH) q.push_back({m_ext, m_brk, kb_data});
        else ovf_set = 1;
        m_ext = 0; m_brk = 0;
      end
    end
    if (en && wr && !addr) begin
      m_ie = din[1];
      if (din[2]) m_ovf = 0;
      if (din[3]) m_err = 0;
    end
    if (ovf_set) m_ovf = 1;
    if (err_set) m_err = 1;
    m_irq = irq_next;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("irq", {31'b0, irq}, {31'b0, m_irq});
      check("wt", {31'b0, wt}, 32'h0);
      if (!(en && wr)) check("data_out", data_out, model_dout());
    end
  end

  task automatic drive(input bit rdy, input logic [7:0] d, input bit e, input bit w,
                       input bit a, input logic [31:0] di);
    kb_rdy = rdy; kb_data = d; en = e; wr = w; addr = a; din = di;
    @(negedge clk);
    last_dout = data_out;
    last_irq  = irq;
    @(posedge clk);
    if (rst_n) model_step();
    #1;
    kb_rdy = 0; en = 0; wr = 0; addr = 0; din = '0;
  endtask

  task automatic kbyte(input logic [7:0] d);  drive(1, d, 0, 0, 0, '0); endtask
  task automatic rd_data();                   drive(0, '0, 1, 0, 1, '0); endtask
  task automatic rd_stat();                   drive(0, '0, 1, 0, 0, '0); endtask
  task automatic wr_stat(input logic [31:0] v); drive(0, '0, 1, 1, 0, v); endtask
  task automatic idle();                      drive(0, '0, 0, 0, 0, '0); endtask

  task automatic do_reset();
    rst_n = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  initial begin
    logic [7:0] pool [4];
    logic [7:0] b;
    model_clear();
    pool[0] = 8'hE0; pool[1] = 8'hF0; pool[2] = 8'h00; pool[3] = 8'hFF;
    chk_en = 1;
    // Reset values while rst_n is held low, with a read selected.
    en = 1; addr = 0;
    @(negedge clk);
    check("rst_status", data_out, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    addr = 1;
    @(negedge clk);
    check("rst_data", data_out, 32'h0);
    en = 0; addr = 0;
    do_reset();

    kbyte(8'h1C); kbyte(8'hF0); kbyte(8'h1C);
    rd_data(); check("make_1C", last_dout, 32'h01C);
    rd_data(); check("break_1C", last_dout, 32'h11C);
    rd_stat(); check("empty_after", last_dout, 32'h0);

    kbyte(8'hE0); kbyte(8'hF0); kbyte(8'h75);
    rd_data(); check("ext_break_75", last_dout, 32'h375);
    kbyte(8'hE0); kbyte(8'hF0); kbyte(8'hE0); kbyte(8'h75);
    rd_data(); check("e0_reset_brk", last_dout, 32'h275);

    wr_stat(32'h2);
    kbyte(8'h29);
    idle(); check("irq_pre", {31'b0, last_irq}, 32'h0);
    idle(); check("irq_rise", {31'b0, last_irq}, 32'h1);
    rd_data(); check("irq_read", last_dout, 32'h029);
    idle(); check("irq_hold", {31'b0, last_irq}, 32'h1);
    idle(); check("irq_fall", {31'b0, last_irq}, 32'h0);
    wr_stat(32'h0);

    do_reset();
    for (int unsigned i = 0; i < DEPTH + 1; i++) kbyte(8'h10 + 8'(i));
    rd_stat(); check("full_ovf", last_dout, (DEPTH << 4) | 32'h5);
    wr_stat(32'h4);
    rd_stat(); check("ovf_clr", last_dout, (DEPTH << 4) | 32'h1);
    drive(1, 8'h55, 1, 0, 1, '0); check("full_pushpop", last_dout, 32'h010);
    rd_stat(); check("full_count", last_dout, (DEPTH << 4) | 32'h1);
    for (int unsigned i = 0; i < DEPTH; i++) begin
      rd_data();
      check("full_order", last_dout, (i == DEPTH - 1) ? 32'h055 : 32'h011 + i);
    end
    kbyte(8'hFF);
    rd_stat(); check("err_ff", last_dout, 32'h8);
    wr_stat(32'h8);
    rd_stat(); check("err_clr", last_dout, 32'h0);
    drive(1, 8'h00, 1, 1, 0, 32'h8);
    rd_stat(); check("err_set_wins", last_dout, 32'h8);

    kbyte(8'h33); kbyte(8'hE0);
    do_reset();
    rd_stat(); check("mid_reset", last_dout, 32'h0);
    kbyte(8'h6B);
    rd_data(); check("after_reset", last_dout, 32'h06B);

    for (int unsigned c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        b = ($urandom_range(0, 2) == 0) ? pool[$urandom_range(0, 3)] : 8'($urandom);
        case ($urandom_range(0, 7))
          0, 1:    drive($urandom_range(0, 1) == 1, b, 1, 0, 1, '0);
          2:       drive($urandom_range(0, 1) == 1, b, 1, 0, 0, '0);
          3:       drive($urandom_range(0, 1) == 1, b, 1, 1, 0, $urandom);
          4:       drive($urandom_range(0, 1) == 1, b, 1, 1, 1, $urandom);
          default: drive($urandom_range(0, 1) == 1, b, 0, 0, 0, '0);
        endcase
      end
    end

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
